// File: rtl/ball_motion.sv
// ball_motion: ball position/direction/speed per frame tick, serves on paddle, bounces off walls and paddles
module ball_motion #(
  parameter logic [9:0]  P1_BOARD_X     = 10'd150,
  parameter logic [9:0]  P2_BOARD_X     = 10'd490,
  parameter logic [9:0]  TOP_Y          = 10'd40,
  parameter logic [9:0]  BOTTOM_Y       = 10'd440,
  parameter logic [9:0]  SERVE_OFFSET   = 10'd8,
  parameter logic [10:0] PAD_HALF       = 11'd32,
  parameter logic [3:0]  STEP_X         = 4'd4,
  parameter logic [3:0]  MAX_STEP_X     = 4'd8,
  parameter logic [9:0]  STEP_Y         = 10'd2,
  parameter logic [3:0]  HITS_PER_LEVEL = 4'd4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic [1:0] game_state,
  input  logic [9:0] p1_pad_y,
  input  logic [9:0] p2_pad_y,
  output logic [9:0] ball_x,
  output logic [9:0] ball_y,
  output logic       ball_dir_x,
  output logic       ball_dir_y,
  output logic [3:0] speed_x,
  output logic [7:0] hit_count,
  output logic       hit_pulse
);
  typedef enum logic [1:0] {P1_SERVE, P2_SERVE, PLAYING, GAME_END} state_t;
  state_t st;
  logic [3:0] level, speed_up;
  logic [10:0] sum_x, y_dn, d1, d2;
  logic [9:0] nx, ny, p1_cl, p2_cl;
  logic hit_l, hit_r, dn_wall, up_wall, lvl_wrap;
  always_comb begin
    st = state_t'(game_state);
    sum_x = {1'b0, ball_x} + {7'd0, speed_x};
    nx = ball_dir_x ? (sum_x[10] ? 10'h3ff : sum_x[9:0])
                    : (ball_x < {6'd0, speed_x} ? 10'd0 : ball_x - {6'd0, speed_x});
    d1 = ball_y >= p1_pad_y ? {1'b0, ball_y - p1_pad_y} : {1'b0, p1_pad_y - ball_y};
    d2 = ball_y >= p2_pad_y ? {1'b0, ball_y - p2_pad_y} : {1'b0, p2_pad_y - ball_y};
    hit_l = !ball_dir_x && ball_x > P1_BOARD_X && nx <= P1_BOARD_X && d1 <= PAD_HALF;
    hit_r = ball_dir_x && ball_x < P2_BOARD_X && nx >= P2_BOARD_X && d2 <= PAD_HALF;
    y_dn = {1'b0, ball_y} + {1'b0, STEP_Y};
    dn_wall = ball_dir_y && y_dn >= {1'b0, BOTTOM_Y};
    up_wall = !ball_dir_y && ball_y <= TOP_Y + STEP_Y;
    ny = ball_dir_y ? (dn_wall ? BOTTOM_Y : y_dn[9:0]) : (up_wall ? TOP_Y : ball_y - STEP_Y);
    p1_cl = p1_pad_y < TOP_Y ? TOP_Y : p1_pad_y > BOTTOM_Y ? BOTTOM_Y : p1_pad_y;
    p2_cl = p2_pad_y < TOP_Y ? TOP_Y : p2_pad_y > BOTTOM_Y ? BOTTOM_Y : p2_pad_y;
    lvl_wrap = level == HITS_PER_LEVEL - 4'd1;
    speed_up = speed_x >= MAX_STEP_X ? MAX_STEP_X : speed_x + 4'd1;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      ball_x <= P1_BOARD_X + SERVE_OFFSET;
      ball_y <= 10'((11'(TOP_Y) + 11'(BOTTOM_Y)) >> 1);
      ball_dir_x <= 1'b1;
      ball_dir_y <= 1'b1;
      speed_x <= STEP_X;
      hit_count <= 8'd0;
      hit_pulse <= 1'b0;
      level <= 4'd0;
    end else begin
      hit_pulse <= 1'b0;
      if (st == P1_SERVE || st == P2_SERVE) begin
        ball_x <= st == P1_SERVE ? P1_BOARD_X + SERVE_OFFSET : P2_BOARD_X - SERVE_OFFSET;
        ball_y <= st == P1_SERVE ? p1_cl : p2_cl;
        ball_dir_x <= st == P1_SERVE;
        speed_x <= STEP_X;
        hit_count <= 8'd0;
        level <= 4'd0;
      end else if (st == PLAYING && tick) begin
        ball_x <= hit_l ? P1_BOARD_X + 10'd1 : hit_r ? P2_BOARD_X - 10'd1 : nx;
        ball_dir_x <= hit_l ? 1'b1 : hit_r ? 1'b0 : ball_dir_x;
        ball_y <= ny;
        ball_dir_y <= ball_dir_y ? !dn_wall : up_wall;
        if (hit_l || hit_r) begin
          hit_pulse <= 1'b1;
          hit_count <= hit_count == 8'hff ? hit_count : hit_count + 8'd1;
          level <= lvl_wrap ? 4'd0 : level + 4'd1;
          if (lvl_wrap) speed_x <= speed_up;
        end
      end
    end
  end
endmodule

// File: tb/tb_ball_motion.sv
// tb_ball_motion: directed stimulus with a behavioural ball model compared every cycle plus literal checks
module tb_ball_motion;
  logic clk = 0, reset = 0, tick = 0;
  logic [1:0] game_state = 2'd3;
  logic [9:0] p1_pad_y = 0, p2_pad_y = 0;
  logic [9:0] ball_x, ball_y;
  logic ball_dir_x, ball_dir_y, hit_pulse;
  logic [3:0] speed_x;
  logic [7:0] hit_count;
  always #5 clk = ~clk;
  ball_motion dut (
    .clk(clk), .reset(reset), .tick(tick), .game_state(game_state),
    .p1_pad_y(p1_pad_y), .p2_pad_y(p2_pad_y), .ball_x(ball_x), .ball_y(ball_y),
    .ball_dir_x(ball_dir_x), .ball_dir_y(ball_dir_y), .speed_x(speed_x),
    .hit_count(hit_count), .hit_pulse(hit_pulse)
  );
  int n_cmp = 0, n_err = 0;
  int m_x, m_y, m_sp, m_hc, m_lv, nx, ny, p1i, p2i;
  bit m_dx, m_dy, m_hp, m_ok = 0, hl, hr;
  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  function automatic int clampi(input int v);
    return v < 40 ? 40 : v > 440 ? 440 : v;
  endfunction
  function automatic int absi(input int v);
    return v < 0 ? -v : v;
  endfunction
  always @(posedge clk) begin
    p1i = int'(p1_pad_y);
    p2i = int'(p2_pad_y);
    m_hp = 0;
    if (!reset) begin
      m_x = 158; m_y = 240; m_dx = 1; m_dy = 1; m_sp = 4; m_hc = 0; m_lv = 0; m_ok = 1;
    end else if (game_state == 2'd0 || game_state == 2'd1) begin
      m_x = game_state == 2'd0 ? 158 : 482;
      m_y = clampi(game_state == 2'd0 ? p1i : p2i);
      m_dx = game_state == 2'd0; m_sp = 4; m_hc = 0; m_lv = 0;
    end else if (game_state == 2'd2 && tick) begin
      nx = m_x + (m_dx ? m_sp : -m_sp);
      nx = nx < 0 ? 0 : nx > 1023 ? 1023 : nx;
      hl = !m_dx && m_x > 150 && nx <= 150 && absi(m_y - p1i) <= 32;
      hr = m_dx && m_x < 490 && nx >= 490 && absi(m_y - p2i) <= 32;
      m_x = hl ? 151 : hr ? 489 : nx;
      if (hl) m_dx = 1;
      if (hr) m_dx = 0;
      ny = m_y + (m_dy ? 2 : -2);
      if (m_dy && ny >= 440) begin ny = 440; m_dy = 0; end
      else if (!m_dy && ny <= 40) begin ny = 40; m_dy = 1; end
      m_y = ny;
      m_hp = hl || hr;
      if (m_hp) begin
        m_hc = m_hc < 255 ? m_hc + 1 : 255;
        m_lv++;
        if (m_lv == 4) begin m_lv = 0; m_sp = m_sp < 8 ? m_sp + 1 : 8; end
      end
    end
  end
  always @(negedge clk) if (m_ok) begin
    chk("m_ball_x", int'(ball_x), m_x);
    chk("m_ball_y", int'(ball_y), m_y);
    chk("m_dir_x", int'(ball_dir_x), int'(m_dx));
    chk("m_dir_y", int'(ball_dir_y), int'(m_dy));
    chk("m_speed_x", int'(speed_x), m_sp);
    chk("m_hit_count", int'(hit_count), m_hc);
    chk("m_hit_pulse", int'(hit_pulse), int'(m_hp));
  end
  task automatic cyc(input int n, input logic t);
    repeat (n) begin tick = t; @(posedge clk); #1; end
    tick = 0;
  endtask
  task automatic pos(input string name, input int x, input int y);
    chk({name, "_x"}, int'(ball_x), x);
    chk({name, "_y"}, int'(ball_y), y);
  endtask
  task automatic rally_to(input int target);
    int guard = 0;
    game_state = 2'd2;
    while (m_hc < target && guard < 5000) begin
      p1_pad_y = 10'(m_y);
      p2_pad_y = 10'(m_y);
      tick = 1;
      @(posedge clk); #1;
      guard++;
    end
    tick = 0;
    if (m_hc < target) begin
      n_cmp++; n_err++;
      $display("FAIL rally_timeout: got %0d hits expected %0d", m_hc, target);
    end
  endtask
  initial begin
    cyc(2, 0);
    pos("reset", 158, 240);
    chk("reset_dir_x", int'(ball_dir_x), 1);
    chk("reset_dir_y", int'(ball_dir_y), 1);
    chk("reset_speed", int'(speed_x), 4);
    chk("reset_hits", int'(hit_count), 0);
    chk("reset_pulse", int'(hit_pulse), 0);
    reset = 1;
    game_state = 2'd0; p1_pad_y = 300; cyc(1, 0);
    pos("serve1", 158, 300);
    p1_pad_y = 20; cyc(1, 0);
    chk("serve_clamp_top", int'(ball_y), 40);
    p1_pad_y = 500; cyc(1, 0);
    chk("serve_clamp_bot", int'(ball_y), 440);
    p1_pad_y = 300; cyc(1, 0);
    game_state = 2'd2; cyc(1, 1);
    pos("first_tick", 162, 302);
    cyc(5, 0);
    pos("no_tick_hold", 162, 302);
    game_state = 2'd0; p1_pad_y = 275; cyc(1, 0);
    game_state = 2'd2; p2_pad_y = 439; cyc(82, 1);
    pos("pre_combo", 486, 439);
    cyc(1, 1);
    pos("combo", 489, 440);
    chk("combo_dir_x", int'(ball_dir_x), 0);
    chk("combo_dir_y", int'(ball_dir_y), 0);
    chk("combo_pulse", int'(hit_pulse), 1);
    chk("combo_hits", int'(hit_count), 1);
    cyc(1, 0);
    chk("pulse_one_cycle", int'(hit_pulse), 0);
    game_state = 2'd1; p2_pad_y = 200; cyc(1, 0);
    pos("serve2", 482, 200);
    game_state = 2'd2; p1_pad_y = 76; cyc(82, 1);
    pos("pre_left_hit", 154, 44);
    cyc(1, 1);
    pos("left_hit_edge", 151, 46);
    chk("left_hit_dir", int'(ball_dir_x), 1);
    chk("left_hit_pulse", int'(hit_pulse), 1);
    game_state = 2'd1; cyc(1, 0);
    game_state = 2'd2; p1_pad_y = 397; cyc(82, 1);
    pos("pre_miss", 154, 364);
    cyc(1, 1);
    pos("miss_33", 150, 366);
    chk("miss_pulse", int'(hit_pulse), 0);
    p1_pad_y = 366; cyc(1, 1);
    chk("no_rehit_x", int'(ball_x), 146);
    chk("no_rehit_pulse", int'(hit_pulse), 0);
    cyc(38, 1);
    chk("sat_zero", int'(ball_x), 0);
    game_state = 2'd0; p1_pad_y = 240; cyc(1, 0);
    rally_to(4);
    chk("speed_after_4", int'(speed_x), 5);
    rally_to(16);
    chk("speed_after_16", int'(speed_x), 8);
    rally_to(20);
    chk("speed_after_20", int'(speed_x), 8);
    chk("hits_20", int'(hit_count), 20);
    game_state = 2'd1; cyc(1, 0);
    chk("p2_serve_x", int'(ball_x), 482);
    chk("p2_serve_speed", int'(speed_x), 4);
    chk("p2_serve_hits", int'(hit_count), 0);
    game_state = 2'd2; cyc(10, 1);
    reset = 0; cyc(1, 1);
    pos("mid_reset", 158, 240);
    chk("mid_reset_speed", int'(speed_x), 4);
    chk("mid_reset_hits", int'(hit_count), 0);
    reset = 1;
    game_state = 2'd0; p1_pad_y = 300; cyc(1, 0);
    game_state = 2'd2; cyc(1, 1);
    game_state = 2'd3; cyc(5, 1);
    pos("game_end_hold", 162, 302);
    cyc(2, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
